button_in_port: RTL and testbench

BUTTON_IN_PORT -- requirements
Module: button_in_port

---
 rtl/button_in_port.sv | 123 ++++++++++++
 tb/tb_button_in_port.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/button_in_port.sv
// ---------------------------------------------------------------------------
// button_in_port
//
// Four-bit pushbutton input port for a small processor. Each raw button level
// is synchronised, debounced, and then either latched as a sticky press event
// that is cleared when the processor reads the port (LATCH_MODE = 1), or
// passed through as a debounced level (LATCH_MODE = 0).
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive sampled cycles a changed level must hold
//                    before it is accepted (2..255)
//   LATCH_MODE       1 = sticky press events cleared on read
//                    0 = debounced level pass-through
//
// Ports
//   clock        single clock, all state updates on its rising edge
//   reset        synchronous reset, active-high
//   btn_raw      asynchronous bouncing button levels, 1 = pressed
//   rd_strobe    one-cycle pulse while the processor executes its IN
//   pushbuttons  registered nibble presented to the processor data input
//   any_pending  registered OR of the reported button bits
//   overrun      per bit, a new press arrived while the previous was unread
// ---------------------------------------------------------------------------
module button_in_port #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned LATCH_MODE      = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] btn_raw,
   input  logic       rd_strobe,
   output logic [3:0] pushbuttons,
   output logic       any_pending,
   output logic [3:0] overrun
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   // The count is accepted on the edge where it would reach DEBOUNCE_CYCLES,
   // so the last value actually held in the counter is DEBOUNCE_CYCLES-1.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]         sync1_r;
   logic [3:0]         sync2_r;
   logic [3:0]         stable_r;
   logic [3:0]         stable_prev_r;
   logic [3:0]         sticky_r;
   logic [3:0]         overrun_r;
   logic               any_pending_r;
   logic [3:0][CW-1:0] cnt_r;

   logic [3:0][CW-1:0] cnt_nxt_s;
   logic [3:0]         stable_nxt_s;
   logic [3:0]         set_s;
   logic [3:0]         sticky_nxt_s;
   logic [3:0]         overrun_nxt_s;
   logic               any_pending_nxt_s;

   // Per-bit debounce: count while the synchronised level disagrees with
   // the accepted level; any agreement restarts the count from zero.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_nxt_s[i]    = {CW{1'b0}};
         stable_nxt_s[i] = stable_r[i];
         if (sync2_r[i] == stable_r[i]) begin
            cnt_nxt_s[i] = {CW{1'b0}};
         end else if (cnt_r[i] == CNT_LAST) begin
            stable_nxt_s[i] = sync2_r[i];
            cnt_nxt_s[i]    = {CW{1'b0}};
         end else begin
            cnt_nxt_s[i] = cnt_r[i] + CW'(1);
         end
      end
   end

   // Press-event latching, overrun tracking and the registered any_pending.
   // A set event on the read edge wins over the clear.
   always_comb begin
      set_s = stable_r & ~stable_prev_r;
      if (LATCH_MODE == 32'd1) begin
         if (rd_strobe) begin
            sticky_nxt_s  = set_s;
            overrun_nxt_s = 4'b0000;
         end else begin
            sticky_nxt_s  = sticky_r | set_s;
            overrun_nxt_s = overrun_r | (set_s & sticky_r);
         end
         any_pending_nxt_s = |sticky_nxt_s;
      end else begin
         sticky_nxt_s      = 4'b0000;
         overrun_nxt_s     = 4'b0000;
         any_pending_nxt_s = |stable_nxt_s;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_r       <= 4'b0000;
         sync2_r       <= 4'b0000;
         stable_r      <= 4'b0000;
         stable_prev_r <= 4'b0000;
         sticky_r      <= 4'b0000;
         overrun_r     <= 4'b0000;
         any_pending_r <= 1'b0;
         cnt_r         <= '{default: {CW{1'b0}}};
      end else begin
         sync1_r       <= btn_raw;
         sync2_r       <= sync1_r;
         stable_r      <= stable_nxt_s;
         stable_prev_r <= stable_r;
         sticky_r      <= sticky_nxt_s;
         overrun_r     <= overrun_nxt_s;
         any_pending_r <= any_pending_nxt_s;
         cnt_r         <= cnt_nxt_s;
      end
   end

   // Outputs come straight from flops; the mode select is a fixed parameter.
   assign pushbuttons = (LATCH_MODE == 32'd1) ? sticky_r : stable_r;
   assign any_pending = any_pending_r;
   assign overrun     = overrun_r;

endmodule

// File: tb/tb_button_in_port.sv
// ---------------------------------------------------------------------------
// tb_button_in_port
//
// Directed bench for button_in_port with DEBOUNCE_CYCLES = 4. One instance
// runs in latch mode, a second in level mode; both share the inputs.
// Inputs change 1 time unit after a rising edge and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_button_in_port;

   logic       clock;
   logic       reset;
   logic [3:0] btn_raw;
   logic       rd_strobe;

   logic [3:0] pb1;
   logic       ap1;
   logic [3:0] ov1;
   logic [3:0] pb0;
   logic       ap0;
   logic [3:0] ov0;

   int n_vec;
   int n_err;

   button_in_port #(.DEBOUNCE_CYCLES(4), .LATCH_MODE(1)) dut_latch (
      .clock       (clock),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .rd_strobe   (rd_strobe),
      .pushbuttons (pb1),
      .any_pending (ap1),
      .overrun     (ov1)
   );

   button_in_port #(.DEBOUNCE_CYCLES(4), .LATCH_MODE(0)) dut_level (
      .clock       (clock),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .rd_strobe   (rd_strobe),
      .pushbuttons (pb0),
      .any_pending (ap0),
      .overrun     (ov0)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      reset     = 1'b1;
      btn_raw   = 4'b0000;
      rd_strobe = 1'b0;

      // reset state, valid from the first edge with reset high
      step();
      chk("rst_pb1", pb1, 4'b0000);
      chk("rst_ap1", {3'b000, ap1}, 4'b0000);
      chk("rst_ov1", ov1, 4'b0000);
      chk("rst_pb0", pb0, 4'b0000);
      chk("rst_ap0", {3'b000, ap0}, 4'b0000);
      step();
      reset = 1'b0;

      // clean press of bit 1: latch after edge 6, level after edge 5
      btn_raw = 4'b0010;
      for (int e = 0; e <= 6; e++) begin
         step();
         chk("press_pb1", pb1, (e >= 6) ? 4'b0010 : 4'b0000);
         chk("press_pb0", pb0, (e >= 5) ? 4'b0010 : 4'b0000);
      end
      chk("press_ap1", {3'b000, ap1}, 4'b0001);
      repeat (3) step();
      chk("press_hold_pb1", pb1, 4'b0010);
      chk("press_hold_ap1", {3'b000, ap1}, 4'b0001);
      btn_raw   = 4'b0000;
      rd_strobe = 1'b1;
      chk("rd1_preclear_pb1", pb1, 4'b0010);
      step();
      rd_strobe = 1'b0;
      chk("rd1_clear_pb1", pb1, 4'b0000);
      chk("rd1_clear_ap1", {3'b000, ap1}, 4'b0000);
      repeat (8) step();

      // bounce on bit 0: high 3, low 1, high 3, low -> never accepted
      for (int i = 0; i < 13; i++) begin
         btn_raw = (i < 3 || (i >= 4 && i < 7)) ? 4'b0001 : 4'b0000;
         step();
         chk("bounce_pb1", pb1, 4'b0000);
         chk("bounce_pb0", pb0, 4'b0000);
      end

      // read clear of bit 2
      btn_raw = 4'b0100;
      repeat (7) step();
      chk("rc_latched_pb1", pb1, 4'b0100);
      rd_strobe = 1'b1;
      chk("rc_strobe_pb1", pb1, 4'b0100);
      step();
      rd_strobe = 1'b0;
      chk("rc_after_pb1", pb1, 4'b0000);
      chk("rc_after_ap1", {3'b000, ap1}, 4'b0000);
      btn_raw = 4'b0000;
      repeat (6) step();

      // overrun on bit 3: second press before any read
      btn_raw = 4'b1000;
      repeat (7) step();
      chk("ov_first_pb1", pb1, 4'b1000);
      chk("ov_first_ov1", ov1, 4'b0000);
      btn_raw = 4'b0000;
      repeat (6) step();
      btn_raw = 4'b1000;
      repeat (6) step();
      chk("ov_before_ov1", ov1, 4'b0000);
      step();
      chk("ov_set_ov1", ov1, 4'b1000);
      chk("ov_set_pb1", pb1, 4'b1000);
      chk("ov_set_ap1", {3'b000, ap1}, 4'b0001);
      btn_raw = 4'b0000;
      repeat (6) step();
      rd_strobe = 1'b1;
      step();
      rd_strobe = 1'b0;
      chk("ov_clear_ov1", ov1, 4'b0000);
      chk("ov_clear_pb1", pb1, 4'b0000);

      // set wins: bit 1 set event on the same edge as rd_strobe
      btn_raw = 4'b0010;
      repeat (6) step();
      rd_strobe = 1'b1;
      step();
      rd_strobe = 1'b0;
      chk("setwin_pb1", pb1, 4'b0010);
      chk("setwin_ov1", ov1, 4'b0000);
      chk("setwin_ap1", {3'b000, ap1}, 4'b0001);
      rd_strobe = 1'b1;
      step();
      rd_strobe = 1'b0;
      chk("setwin_clear_pb1", pb1, 4'b0000);
      btn_raw = 4'b0000;
      repeat (6) step();

      // reset mid-debounce with sticky 0011, buttons held through reset
      btn_raw = 4'b0011;
      repeat (7) step();
      chk("midrst_pre_pb1", pb1, 4'b0011);
      btn_raw = 4'b0111;
      repeat (3) step();
      reset     = 1'b1;
      rd_strobe = 1'b1;
      step();
      reset     = 1'b0;
      rd_strobe = 1'b0;
      chk("midrst_pb1", pb1, 4'b0000);
      chk("midrst_ap1", {3'b000, ap1}, 4'b0000);
      chk("midrst_ov1", ov1, 4'b0000);
      chk("midrst_pb0", pb0, 4'b0000);
      chk("midrst_ap0", {3'b000, ap0}, 4'b0000);
      for (int e = 1; e <= 7; e++) begin
         step();
         chk("postrst_pb1", pb1, (e >= 7) ? 4'b0111 : 4'b0000);
         chk("postrst_pb0", pb0, (e >= 6) ? 4'b0111 : 4'b0000);
      end
      rd_strobe = 1'b1;
      step();
      rd_strobe = 1'b0;
      btn_raw   = 4'b0000;
      repeat (6) step();

      // level mode: press and release of bit 2, rd_strobe ignored
      btn_raw = 4'b0100;
      for (int e = 0; e <= 5; e++) begin
         step();
         chk("lvl_rise_pb0", pb0, (e >= 5) ? 4'b0100 : 4'b0000);
      end
      chk("lvl_rise_ap0", {3'b000, ap0}, 4'b0001);
      rd_strobe = 1'b1;
      step();
      rd_strobe = 1'b0;
      chk("lvl_rd_pb0", pb0, 4'b0100);
      chk("lvl_rd_ov0", ov0, 4'b0000);
      btn_raw = 4'b0000;
      for (int e = 0; e <= 5; e++) begin
         step();
         chk("lvl_fall_pb0", pb0, (e >= 5) ? 4'b0000 : 4'b0100);
      end
      chk("lvl_fall_ap0", {3'b000, ap0}, 4'b0000);
      chk("lvl_end_ov0", ov0, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
